// File: rtl/mem_arbiter.sv
// mem_arbiter
// Round-robin sequencer for the single 16-bit memory port shared by the
// instruction-fetch stage (IF) and the data-memory stage (DM). One access is
// in flight at a time: IDLE picks a requester, ACCESS drives the memory for
// WAIT+1 cycles, and RESP (reads only) captures the synchronous read data
// into the owner's read-data register.
//
// Parameters:
//   WAIT       extra memory cycles per access (0..15)
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   IF_REQ     fetch read request, held until IF_GNT
//   IF_ADDR    fetch address
//   IF_GNT     one-cycle pulse, fetch request accepted
//   IF_RVALID  one-cycle pulse, IF_RDATA holds a new instruction
//   IF_RDATA   registered read data for fetch
//   DM_REQ     data request, held until DM_GNT
//   DM_WE      1 = write, 0 = read
//   DM_ADDR    data address
//   DM_WDATA   data write data
//   DM_GNT     one-cycle pulse, data request accepted
//   DM_RVALID  one-cycle pulse, DM_RDATA holds new read data
//   DM_RDATA   registered read data for the data stage
//   MEM_ADDR   memory address (holds its last value outside ACCESS)
//   MEM_WE     memory write strobe, final ACCESS cycle of a write only
//   MEM_WDATA  memory write data (holds its last value outside ACCESS)
//   MEM_RDATA  memory read data, valid the cycle after the final ACCESS cycle
//   BUSY       high whenever the sequencer is not IDLE
module mem_arbiter #(
  parameter int unsigned WAIT = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [15:0] IF_ADDR,
  output logic        IF_GNT,
  output logic        IF_RVALID,
  output logic [15:0] IF_RDATA,
  input  logic        DM_REQ,
  input  logic        DM_WE,
  input  logic [15:0] DM_ADDR,
  input  logic [15:0] DM_WDATA,
  output logic        DM_GNT,
  output logic        DM_RVALID,
  output logic [15:0] DM_RDATA,
  output logic [15:0] MEM_ADDR,
  output logic        MEM_WE,
  output logic [15:0] MEM_WDATA,
  input  logic [15:0] MEM_RDATA,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;
  localparam logic [3:0] WAIT_CNT = WAIT[3:0];

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last;
  logic       cur_we;
  logic       pick_dm;

  // Arbitration decision for the IDLE cycle. A lone requester wins outright;
  // on a tie the requester that did not win last time gets the port, which is
  // what makes grants alternate while both stages keep asking.
  always_comb begin
    pick_dm = 1'b0;
    if (IF_REQ && DM_REQ) begin
      pick_dm = (last == OWN_IF);
    end else begin
      pick_dm = DM_REQ;
    end
  end

  // The whole sequencer lives in this one block so every output is a flop.
  // Pulses (GNT, RVALID, MEM_WE) default low each cycle and are only raised
  // on the edge that enters the cycle they belong to. MEM_ADDR and MEM_WDATA
  // double as the latched request, so they naturally hold outside ACCESS.
  // MEM_WE is set one edge early: on entry when WAIT is 0, otherwise when
  // the counter is about to reach 0, so it is high in the final cycle only.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner     <= OWN_IF;
      last      <= OWN_IF;
      cur_we    <= 1'b0;
      IF_GNT    <= 1'b0;
      IF_RVALID <= 1'b0;
      IF_RDATA  <= 16'h0000;
      DM_GNT    <= 1'b0;
      DM_RVALID <= 1'b0;
      DM_RDATA  <= 16'h0000;
      MEM_ADDR  <= 16'h0000;
      MEM_WE    <= 1'b0;
      MEM_WDATA <= 16'h0000;
    end else begin
      IF_GNT    <= 1'b0;
      DM_GNT    <= 1'b0;
      IF_RVALID <= 1'b0;
      DM_RVALID <= 1'b0;
      MEM_WE    <= 1'b0;
      case (state)
        IDLE: begin
          if (IF_REQ || DM_REQ) begin
            owner <= pick_dm;
            last  <= pick_dm;
            cnt   <= WAIT_CNT;
            state <= ACCESS;
            if (pick_dm) begin
              MEM_ADDR  <= DM_ADDR;
              MEM_WDATA <= DM_WDATA;
              cur_we    <= DM_WE;
              DM_GNT    <= 1'b1;
              MEM_WE    <= DM_WE && (WAIT_CNT == 4'd0);
            end else begin
              MEM_ADDR  <= IF_ADDR;
              MEM_WDATA <= 16'h0000;
              cur_we    <= 1'b0;
              IF_GNT    <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= cur_we ? IDLE : RESP;
          end else begin
            cnt    <= cnt - 4'd1;
            MEM_WE <= cur_we && (cnt == 4'd1);
          end
        end
        RESP: begin
          if (owner == OWN_DM) begin
            DM_RDATA  <= MEM_RDATA;
            DM_RVALID <= 1'b1;
          end else begin
            IF_RDATA  <= MEM_RDATA;
            IF_RVALID <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed bench for mem_arbiter. Three instances run side by side with
// WAIT = 0, 2 and 3, each with its own synchronous-read memory model
// (1-cycle latency). Inputs are driven and outputs sampled 1 time unit after
// each rising clock edge, so the "cycle N" comments below refer to the cycle
// that begins at that edge.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [3];
  logic        if_req    [3];
  logic [15:0] if_addr   [3];
  logic        dm_req    [3];
  logic        dm_we     [3];
  logic [15:0] dm_addr   [3];
  logic [15:0] dm_wdata  [3];
  logic        if_gnt    [3];
  logic        if_rvalid [3];
  logic [15:0] if_rdata  [3];
  logic        dm_gnt    [3];
  logic        dm_rvalid [3];
  logic [15:0] dm_rdata  [3];
  logic [15:0] mem_addr  [3];
  logic        mem_we    [3];
  logic [15:0] mem_wdata [3];
  logic        busy      [3];

  logic        pre_we   = 1'b0;
  int          pre_sel  = 0;
  logic [11:0] pre_addr = 12'h000;
  logic [15:0] pre_data = 16'h0000;

  int vectors     = 0;
  int miscompares = 0;

  // One DUT plus memory model per WAIT setting. The memory model also keeps a
  // sticky flag of any write strobe seen since that instance's last reset.
  for (genvar g = 0; g < 3; g++) begin : g_inst
    logic [15:0] mem [4096];
    logic [15:0] mem_rdata;
    logic        seen_we;

    mem_arbiter #(.WAIT(g == 0 ? 0 : g + 1)) u_dut (
      .CLK       (clk),
      .RST       (rst[g]),
      .IF_REQ    (if_req[g]),
      .IF_ADDR   (if_addr[g]),
      .IF_GNT    (if_gnt[g]),
      .IF_RVALID (if_rvalid[g]),
      .IF_RDATA  (if_rdata[g]),
      .DM_REQ    (dm_req[g]),
      .DM_WE     (dm_we[g]),
      .DM_ADDR   (dm_addr[g]),
      .DM_WDATA  (dm_wdata[g]),
      .DM_GNT    (dm_gnt[g]),
      .DM_RVALID (dm_rvalid[g]),
      .DM_RDATA  (dm_rdata[g]),
      .MEM_ADDR  (mem_addr[g]),
      .MEM_WE    (mem_we[g]),
      .MEM_WDATA (mem_wdata[g]),
      .MEM_RDATA (mem_rdata),
      .BUSY      (busy[g])
    );

    always @(posedge clk) begin
      if (pre_we && pre_sel == g) begin
        mem[pre_addr] <= pre_data;
      end else if (mem_we[g]) begin
        mem[mem_addr[g][11:0]] <= mem_wdata[g];
      end
      mem_rdata <= mem[mem_addr[g][11:0]];
      if (rst[g]) begin
        seen_we <= 1'b0;
      end else if (mem_we[g]) begin
        seen_we <= 1'b1;
      end
    end
  end

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int sel, input logic [11:0] addr, input logic [15:0] data);
    pre_sel  = sel;
    pre_addr = addr;
    pre_data = data;
    pre_we   = 1'b1;
    applyStimulus(1);
    pre_we   = 1'b0;
  endtask

  task automatic checkIdleOutputs(input int k, input string tag);
    checkOutput({tag, " if_gnt"},    16'(if_gnt[k]),    16'h0);
    checkOutput({tag, " dm_gnt"},    16'(dm_gnt[k]),    16'h0);
    checkOutput({tag, " if_rvalid"}, 16'(if_rvalid[k]), 16'h0);
    checkOutput({tag, " dm_rvalid"}, 16'(dm_rvalid[k]), 16'h0);
    checkOutput({tag, " mem_we"},    16'(mem_we[k]),    16'h0);
    checkOutput({tag, " busy"},      16'(busy[k]),      16'h0);
    checkOutput({tag, " mem_addr"},  mem_addr[k],       16'h0000);
    checkOutput({tag, " mem_wdata"}, mem_wdata[k],      16'h0000);
    checkOutput({tag, " if_rdata"},  if_rdata[k],       16'h0000);
    checkOutput({tag, " dm_rdata"},  dm_rdata[k],       16'h0000);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k]      = 1'b1;
      if_req[k]   = 1'b0;
      if_addr[k]  = 16'h0000;
      dm_req[k]   = 1'b0;
      dm_we[k]    = 1'b0;
      dm_addr[k]  = 16'h0000;
      dm_wdata[k] = 16'h0000;
    end
    applyStimulus(2);
    preload(0, 12'h010, 16'h1234);
    preload(0, 12'h020, 16'h5678);
    preload(1, 12'h040, 16'hA5A5);
    preload(1, 12'h050, 16'h0B0B);
    preload(1, 12'h060, 16'h0C0C);
    preload(2, 12'h030, 16'hDEAD);

    $display("[TB] reset state");
    checkIdleOutputs(0, "rst0");
    checkIdleOutputs(1, "rst1");
    checkIdleOutputs(2, "rst2");
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    // ---- single fetch read, WAIT=0 ----
    $display("[TB] fetch read WAIT=0");
    if_req[0]  = 1'b1;
    if_addr[0] = 16'h0010;
    applyStimulus(1);
    checkOutput("rd0 c1 if_gnt",   16'(if_gnt[0]), 16'h1);
    checkOutput("rd0 c1 dm_gnt",   16'(dm_gnt[0]), 16'h0);
    checkOutput("rd0 c1 mem_addr", mem_addr[0],    16'h0010);
    checkOutput("rd0 c1 busy",     16'(busy[0]),   16'h1);
    if_req[0] = 1'b0;
    applyStimulus(1);
    checkOutput("rd0 c2 if_gnt",    16'(if_gnt[0]),    16'h0);
    checkOutput("rd0 c2 if_rvalid", 16'(if_rvalid[0]), 16'h0);
    checkOutput("rd0 c2 busy",      16'(busy[0]),      16'h1);
    applyStimulus(1);
    checkOutput("rd0 c3 if_rvalid", 16'(if_rvalid[0]), 16'h1);
    checkOutput("rd0 c3 if_rdata",  if_rdata[0],       16'h1234);
    checkOutput("rd0 c3 dm_rvalid", 16'(dm_rvalid[0]), 16'h0);
    checkOutput("rd0 c3 dm_rdata",  dm_rdata[0],       16'h0000);
    checkOutput("rd0 c3 busy",      16'(busy[0]),      16'h0);

    // ---- data write, WAIT=0, then read it back ----
    $display("[TB] data write WAIT=0");
    dm_req[0]   = 1'b1;
    dm_we[0]    = 1'b1;
    dm_addr[0]  = 16'h0100;
    dm_wdata[0] = 16'hBEEF;
    applyStimulus(1);
    checkOutput("wr0 c1 dm_gnt",    16'(dm_gnt[0]), 16'h1);
    checkOutput("wr0 c1 mem_we",    16'(mem_we[0]), 16'h1);
    checkOutput("wr0 c1 mem_addr",  mem_addr[0],    16'h0100);
    checkOutput("wr0 c1 mem_wdata", mem_wdata[0],   16'hBEEF);
    dm_req[0] = 1'b0;
    dm_we[0]  = 1'b0;
    applyStimulus(1);
    checkOutput("wr0 c2 mem_we",    16'(mem_we[0]),    16'h0);
    checkOutput("wr0 c2 busy",      16'(busy[0]),      16'h0);
    checkOutput("wr0 c2 dm_rvalid", 16'(dm_rvalid[0]), 16'h0);
    applyStimulus(1);
    checkOutput("wr0 c3 dm_rvalid", 16'(dm_rvalid[0]), 16'h0);
    dm_req[0] = 1'b1;
    applyStimulus(1);
    checkOutput("rb0 c1 dm_gnt", 16'(dm_gnt[0]), 16'h1);
    checkOutput("rb0 c1 mem_we", 16'(mem_we[0]), 16'h0);
    dm_req[0] = 1'b0;
    applyStimulus(2);
    checkOutput("rb0 c3 dm_rvalid", 16'(dm_rvalid[0]), 16'h1);
    checkOutput("rb0 c3 dm_rdata",  dm_rdata[0],       16'hBEEF);
    checkOutput("rb0 c3 if_rvalid", 16'(if_rvalid[0]), 16'h0);
    checkOutput("rb0 c3 if_rdata",  if_rdata[0],       16'h1234);

    // ---- tie after reset: DM first, then strict alternation ----
    $display("[TB] tie after reset");
    rst[0] = 1'b1;
    applyStimulus(1);
    rst[0]      = 1'b0;
    if_req[0]   = 1'b1;
    if_addr[0]  = 16'h0010;
    dm_req[0]   = 1'b1;
    dm_we[0]    = 1'b0;
    dm_addr[0]  = 16'h0020;
    applyStimulus(1);
    checkOutput("tie c1 dm_gnt",   16'(dm_gnt[0]), 16'h1);
    checkOutput("tie c1 if_gnt",   16'(if_gnt[0]), 16'h0);
    checkOutput("tie c1 mem_addr", mem_addr[0],    16'h0020);
    applyStimulus(2);
    checkOutput("tie c3 dm_rvalid", 16'(dm_rvalid[0]), 16'h1);
    checkOutput("tie c3 dm_rdata",  dm_rdata[0],       16'h5678);
    checkOutput("tie c3 busy",      16'(busy[0]),      16'h0);
    applyStimulus(1);
    checkOutput("tie c4 if_gnt",   16'(if_gnt[0]), 16'h1);
    checkOutput("tie c4 dm_gnt",   16'(dm_gnt[0]), 16'h0);
    checkOutput("tie c4 mem_addr", mem_addr[0],    16'h0010);
    applyStimulus(2);
    checkOutput("tie c6 if_rvalid", 16'(if_rvalid[0]), 16'h1);
    checkOutput("tie c6 if_rdata",  if_rdata[0],       16'h1234);
    applyStimulus(1);
    checkOutput("tie c7 dm_gnt", 16'(dm_gnt[0]), 16'h1);
    checkOutput("tie c7 if_gnt", 16'(if_gnt[0]), 16'h0);
    if_req[0] = 1'b0;
    dm_req[0] = 1'b0;
    applyStimulus(3);

    // ---- WAIT=2 fetch read ----
    $display("[TB] fetch read WAIT=2");
    if_req[1]  = 1'b1;
    if_addr[1] = 16'h0040;
    applyStimulus(1);
    checkOutput("w2 c1 if_gnt",   16'(if_gnt[1]), 16'h1);
    checkOutput("w2 c1 mem_addr", mem_addr[1],    16'h0040);
    checkOutput("w2 c1 busy",     16'(busy[1]),   16'h1);
    if_req[1] = 1'b0;
    applyStimulus(1);
    checkOutput("w2 c2 if_gnt",   16'(if_gnt[1]), 16'h0);
    checkOutput("w2 c2 mem_addr", mem_addr[1],    16'h0040);
    checkOutput("w2 c2 busy",     16'(busy[1]),   16'h1);
    applyStimulus(1);
    checkOutput("w2 c3 mem_addr",  mem_addr[1],       16'h0040);
    checkOutput("w2 c3 if_rvalid", 16'(if_rvalid[1]), 16'h0);
    checkOutput("w2 c3 busy",      16'(busy[1]),      16'h1);
    applyStimulus(1);
    checkOutput("w2 c4 if_rvalid", 16'(if_rvalid[1]), 16'h0);
    checkOutput("w2 c4 busy",      16'(busy[1]),      16'h1);
    applyStimulus(1);
    checkOutput("w2 c5 if_rvalid", 16'(if_rvalid[1]), 16'h1);
    checkOutput("w2 c5 if_rdata",  if_rdata[1],       16'hA5A5);
    checkOutput("w2 c5 busy",      16'(busy[1]),      16'h0);

    // ---- input changes during ACCESS are ignored (WAIT=2) ----
    $display("[TB] inputs ignored outside IDLE");
    if_req[1]  = 1'b1;
    if_addr[1] = 16'h0050;
    applyStimulus(1);
    checkOutput("ign c1 if_gnt", 16'(if_gnt[1]), 16'h1);
    if_req[1]  = 1'b0;
    if_addr[1] = 16'h0077;
    dm_req[1]  = 1'b1;
    dm_we[1]   = 1'b0;
    dm_addr[1] = 16'h0060;
    applyStimulus(1);
    checkOutput("ign c2 mem_addr", mem_addr[1],    16'h0050);
    checkOutput("ign c2 dm_gnt",   16'(dm_gnt[1]), 16'h0);
    applyStimulus(1);
    checkOutput("ign c3 mem_addr", mem_addr[1],    16'h0050);
    checkOutput("ign c3 dm_gnt",   16'(dm_gnt[1]), 16'h0);
    applyStimulus(1);
    checkOutput("ign c4 dm_gnt", 16'(dm_gnt[1]), 16'h0);
    applyStimulus(1);
    checkOutput("ign c5 if_rvalid", 16'(if_rvalid[1]), 16'h1);
    checkOutput("ign c5 if_rdata",  if_rdata[1],       16'h0B0B);
    checkOutput("ign c5 dm_gnt",    16'(dm_gnt[1]),    16'h0);
    applyStimulus(1);
    checkOutput("ign c6 dm_gnt",   16'(dm_gnt[1]), 16'h1);
    checkOutput("ign c6 mem_addr", mem_addr[1],    16'h0060);
    dm_req[1] = 1'b0;
    applyStimulus(4);
    checkOutput("ign c10 dm_rvalid", 16'(dm_rvalid[1]), 16'h1);
    checkOutput("ign c10 dm_rdata",  dm_rdata[1],       16'h0C0C);

    // ---- reset in the middle of a WAIT=3 write ----
    $display("[TB] reset mid-access WAIT=3");
    dm_req[2]   = 1'b1;
    dm_we[2]    = 1'b1;
    dm_addr[2]  = 16'h0030;
    dm_wdata[2] = 16'h1111;
    applyStimulus(1);
    checkOutput("mr c1 dm_gnt",   16'(dm_gnt[2]), 16'h1);
    checkOutput("mr c1 mem_we",   16'(mem_we[2]), 16'h0);
    checkOutput("mr c1 mem_addr", mem_addr[2],    16'h0030);
    dm_req[2] = 1'b0;
    applyStimulus(1);
    checkOutput("mr c2 mem_we", 16'(mem_we[2]), 16'h0);
    checkOutput("mr c2 busy",   16'(busy[2]),   16'h1);
    rst[2] = 1'b1;
    applyStimulus(1);
    rst[2] = 1'b0;
    checkIdleOutputs(2, "mr c3");
    for (int c = 4; c < 9; c++) begin
      applyStimulus(1);
      checkOutput("mr post mem_we",    16'(mem_we[2]),    16'h0);
      checkOutput("mr post dm_rvalid", 16'(dm_rvalid[2]), 16'h0);
      checkOutput("mr post busy",      16'(busy[2]),      16'h0);
    end
    checkOutput("mr no write strobe", 16'(g_inst[2].seen_we), 16'h0);
    checkOutput("mr mem untouched",   g_inst[2].mem[12'h030], 16'hDEAD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
